debounce_bank: RTL and testbench

Multi-channel, tick-prescaled switch/button debouncer for the sale terminal keypad and switch inputs. Each channel has its own two-stage synchroniser and stability counter. Each channel produces:
- a clean debounced level
- one-cycle press and release pulses
- a long-press flag with auto-repeat pulses

It sits between the raw FPGA pins and the terminal's input decoder/FSM. It supersedes single-channel debouncers.

---
 rtl/debounce_bank.sv | 127 ++++++++++++
 tb/tb_debounce_bank.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | debounce_bank                                                               |
// | Multi-channel tick-prescaled debouncer with press/release pulses, long-press |
// | flag and auto-repeat pulses.                                                |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module debounce_bank #(
  parameter int                  CHANNELS         = 4,
  parameter int                  COUNTER_REG_SIZE = 8,
  parameter int                  DEBOUNCE_TICKS   = 20,
  parameter logic [CHANNELS-1:0] INVERT_MASK      = '0,
  parameter int                  HOLD_REG_SIZE    = 12,
  parameter int                  HOLD_TICKS       = 1000,
  parameter int                  REPEAT_TICKS     = 200
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                Tick,
  input  logic [CHANNELS-1:0] NoisyIn,
  output logic [CHANNELS-1:0] CleanOut,
  output logic [CHANNELS-1:0] PressPulse,
  output logic [CHANNELS-1:0] ReleasePulse,
  output logic [CHANNELS-1:0] Held,
  output logic [CHANNELS-1:0] HoldPulse,
  output logic                AnyPress
);

  localparam logic [COUNTER_REG_SIZE-1:0] c_DB_LAST   = COUNTER_REG_SIZE'(DEBOUNCE_TICKS - 1);
  localparam logic [HOLD_REG_SIZE-1:0]    c_HOLD_LAST = HOLD_REG_SIZE'(HOLD_TICKS - 1);
  localparam logic [HOLD_REG_SIZE-1:0]    c_RPT_LAST  =
    HOLD_REG_SIZE'((REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0);
  localparam bit                          c_REPEAT_EN = (REPEAT_TICKS > 0);

  if ((CHANNELS < 1) || (CHANNELS > 32) ||
      (DEBOUNCE_TICKS < 1) || (DEBOUNCE_TICKS > (2**COUNTER_REG_SIZE) - 1) ||
      (HOLD_TICKS < 1) || (HOLD_TICKS > (2**HOLD_REG_SIZE) - 1) ||
      (REPEAT_TICKS < 0) || (REPEAT_TICKS > (2**HOLD_REG_SIZE) - 1)) begin : g_param_check
    $error("debounce_bank: parameter out of range");
  end

  assign AnyPress = |PressPulse;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic                        r_sync0, r_sync1, r_clean;
    logic                        r_press, r_release;
    logic                        r_held, r_hold_pulse, r_repeat;
    logic [COUNTER_REG_SIZE-1:0] r_db_cnt;
    logic [HOLD_REG_SIZE-1:0]    r_hold_cnt;
    logic                        w_in, w_accept, w_rise, w_fall;

    assign w_in     = NoisyIn[i] ^ INVERT_MASK[i];
    assign w_accept = (r_sync1 != r_clean) && Tick && (r_db_cnt == c_DB_LAST);
    assign w_rise   = w_accept && !r_clean;
    assign w_fall   = w_accept && r_clean;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_sync0   <= 1'b0;
        r_sync1   <= 1'b0;
        r_clean   <= 1'b0;
        r_db_cnt  <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_sync0   <= w_in;
        r_sync1   <= r_sync0;
        r_press   <= w_rise;
        r_release <= w_fall;
        // Agreement at any cycle restarts the count, so a glitch costs a full window.
        if (r_sync1 == r_clean) begin
          r_db_cnt <= '0;
        end else if (w_accept) begin
          r_clean  <= ~r_clean;
          r_db_cnt <= '0;
        end else if (Tick) begin
          r_db_cnt <= r_db_cnt + COUNTER_REG_SIZE'(1);
        end
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_hold_cnt   <= '0;
        r_repeat     <= 1'b0;
        r_held       <= 1'b0;
        r_hold_pulse <= 1'b0;
      end else begin
        r_hold_pulse <= 1'b0;
        // A falling edge overrides any threshold reached on the same cycle.
        if (!r_clean || w_fall) begin
          r_hold_cnt <= '0;
          r_repeat   <= 1'b0;
          r_held     <= 1'b0;
        end else if (Tick) begin
          if (!r_repeat) begin
            if (r_hold_cnt == c_HOLD_LAST) begin
              r_hold_pulse <= 1'b1;
              r_held       <= 1'b1;
              r_hold_cnt   <= '0;
              r_repeat     <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_REG_SIZE'(1);
            end
          end else if (c_REPEAT_EN) begin
            if (r_hold_cnt == c_RPT_LAST) begin
              r_hold_pulse <= 1'b1;
              r_hold_cnt   <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_REG_SIZE'(1);
            end
          end else if (r_hold_cnt != '1) begin
            r_hold_cnt <= r_hold_cnt + HOLD_REG_SIZE'(1);
          end
        end
      end
    end

    assign CleanOut[i]     = r_clean;
    assign PressPulse[i]   = r_press;
    assign ReleasePulse[i] = r_release;
    assign Held[i]         = r_held;
    assign HoldPulse[i]    = r_hold_pulse;
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// Testbench for debounce_bank: per-scenario tasks with a scoreboard of
// expected output vectors, compared every cycle.
module tb_debounce_bank;

  logic       CLK;
  logic       RST_N;
  logic       Tick;
  logic [1:0] NoisyIn;
  logic [1:0] CleanOut, PressPulse, ReleasePulse, Held, HoldPulse;
  logic       AnyPress;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [10:0] got, exp_v;
  logic [10:0] sb[$];

  debounce_bank #(
    .CHANNELS        (2),
    .COUNTER_REG_SIZE(8),
    .DEBOUNCE_TICKS  (4),
    .INVERT_MASK     (2'b10),
    .HOLD_REG_SIZE   (12),
    .HOLD_TICKS      (10),
    .REPEAT_TICKS    (3)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .Tick        (Tick),
    .NoisyIn     (NoisyIn),
    .CleanOut    (CleanOut),
    .PressPulse  (PressPulse),
    .ReleasePulse(ReleasePulse),
    .Held        (Held),
    .HoldPulse   (HoldPulse),
    .AnyPress    (AnyPress)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Expected vector layout: {CleanOut, PressPulse, ReleasePulse, Held, HoldPulse, AnyPress}
  function automatic logic [10:0] pk(input logic [1:0] c, p, r, h, hp);
    return {c, p, r, h, hp, |p};
  endfunction

  function automatic logic [10:0] observed();
    return {CleanOut, PressPulse, ReleasePulse, Held, HoldPulse, AnyPress};
  endfunction

  task automatic test_reset();
    RST_N = 1'b0; Tick = 1'b1; NoisyIn = 2'b10;
    #2;
    got = observed(); n_total++;
    if (got !== 11'b0) $display("FAIL reset_async got=%b exp=%b", got, 11'b0); else n_pass++;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      sb.push_back(pk(2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
      @(posedge CLK); #1;
      got = observed(); exp_v = sb.pop_front(); n_total++;
      if (got !== exp_v) $display("FAIL reset_idle k=%0d got=%b exp=%b", k, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_press();
    for (int k = 1; k <= 14; k++) begin
      NoisyIn[0] = (k <= 6);
      sb.push_back(pk({1'b0, k >= 6 && k <= 11}, {1'b0, k == 6}, {1'b0, k == 12}, 2'b00, 2'b00));
      @(posedge CLK); #1;
      got = observed(); exp_v = sb.pop_front(); n_total++;
      if (got !== exp_v) $display("FAIL press k=%0d got=%b exp=%b", k, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    for (int k = 1; k <= 26; k++) begin
      if (k <= 12)      NoisyIn[0] = (((k - 1) / 2) % 2 == 0);
      else if (k <= 18) NoisyIn[0] = 1'b1;
      else              NoisyIn[0] = 1'b0;
      sb.push_back(pk({1'b0, k >= 18 && k <= 23}, {1'b0, k == 18}, {1'b0, k == 24}, 2'b00, 2'b00));
      @(posedge CLK); #1;
      got = observed(); exp_v = sb.pop_front(); n_total++;
      if (got !== exp_v) $display("FAIL bounce k=%0d got=%b exp=%b", k, got, exp_v);
      else n_pass++;
    end
  endtask

  // Release lands on the cycle a repeat pulse would otherwise be due.
  task automatic test_long_press();
    logic hp;
    for (int k = 1; k <= 42; k++) begin
      NoisyIn[0] = (k <= 31);
      hp = (k >= 16) && (k <= 36) && ((k - 16) % 3 == 0);
      sb.push_back(pk({1'b0, k >= 6 && k <= 36}, {1'b0, k == 6}, {1'b0, k == 37},
                      {1'b0, k >= 16 && k <= 36}, {1'b0, hp}));
      @(posedge CLK); #1;
      got = observed(); exp_v = sb.pop_front(); n_total++;
      if (got !== exp_v) $display("FAIL long_press k=%0d got=%b exp=%b", k, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_active_low();
    for (int k = 1; k <= 14; k++) begin
      NoisyIn[1] = !(k <= 6);
      sb.push_back(pk({k >= 6 && k <= 11, 1'b0}, {k == 6, 1'b0}, {k == 12, 1'b0}, 2'b00, 2'b00));
      @(posedge CLK); #1;
      got = observed(); exp_v = sb.pop_front(); n_total++;
      if (got !== exp_v) $display("FAIL active_low k=%0d got=%b exp=%b", k, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    logic c, p, r;
    for (int k = 1; k <= 14; k++) begin
      NoisyIn = (k <= 6) ? 2'b01 : 2'b10;
      c = (k >= 6 && k <= 11); p = (k == 6); r = (k == 12);
      sb.push_back(pk({c, c}, {p, p}, {r, r}, 2'b00, 2'b00));
      @(posedge CLK); #1;
      got = observed(); exp_v = sb.pop_front(); n_total++;
      if (got !== exp_v) $display("FAIL simultaneous k=%0d got=%b exp=%b", k, got, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_tick_prescale();
    for (int k = 1; k <= 34; k++) begin
      Tick = (k % 4 == 0);
      NoisyIn[0] = (k <= 16);
      sb.push_back(pk({1'b0, k >= 16 && k <= 31}, {1'b0, k == 16}, {1'b0, k == 32}, 2'b00, 2'b00));
      @(posedge CLK); #1;
      got = observed(); exp_v = sb.pop_front(); n_total++;
      if (got !== exp_v) $display("FAIL tick_prescale k=%0d got=%b exp=%b", k, got, exp_v);
      else n_pass++;
    end
    Tick = 1'b1;
  endtask

  task automatic test_reset_mid_hold();
    logic hp, c, h;
    for (int k = 1; k <= 36; k++) begin
      NoisyIn[0] = (k <= 28);
      if (k == 20) begin
        RST_N = 1'b0;
        #1;
        got = observed(); n_total++;
        if (got !== 11'b0) $display("FAIL reset_mid_hold_async got=%b exp=%b", got, 11'b0);
        else n_pass++;
      end
      if (k == 21) RST_N = 1'b1;
      hp = (k >= 16) && (k <= 19) && ((k - 16) % 3 == 0);
      c  = (k >= 6 && k <= 19) || (k >= 26 && k <= 33);
      h  = (k >= 16 && k <= 19);
      sb.push_back(pk({1'b0, c}, {1'b0, k == 6 || k == 26}, {1'b0, k == 34}, {1'b0, h}, {1'b0, hp}));
      @(posedge CLK); #1;
      got = observed(); exp_v = sb.pop_front(); n_total++;
      if (got !== exp_v) $display("FAIL reset_mid_hold k=%0d got=%b exp=%b", k, got, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_long_press();
    test_active_low();
    test_simultaneous();
    test_tick_prescale();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
